// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
//   REG_ADDR_W / REG_W / REG_NUM : register address width, data width, register count
//   NOP_REG_ADDR                 : register 0, writes to it are discarded
//   arb_state_e                  : arbiter FSM state (IDLE / DRAIN / FORCE, 2 bits)
//   wr_entry_t                   : buffered B-side write {addr, data}
package regfile_wr_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_NUM    = 32;

    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam logic [REG_W-1:0]      ZERO_WORD    = '0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_DRAIN = 2'b01,
        ARB_FORCE = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } wr_entry_t;

    // True for the hard-wired zero register.
    function automatic logic is_nop_addr(input logic [REG_ADDR_W-1:0] addr);
        return addr == NOP_REG_ADDR;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bus bundle around the regfile write arbiter.
//   A side   : a_we, a_waddr, a_wdata            (WB stage)
//   B side   : b_valid, b_ready, b_waddr, b_wdata (multi-cycle unit)
//   Decode   : re1, raddr1, re2, raddr2          (read-port mirror for hazard check)
//   Regfile  : rf_we, rf_waddr, rf_wdata         (write port)
//   Control  : stall_o
// slave = arbiter view, master = surrounding pipeline / bench view.
interface regfile_wr_arbiter_if;
    import regfile_wr_arbiter_pkg::*;

    logic                  a_we;
    logic [REG_ADDR_W-1:0] a_waddr;
    logic [REG_W-1:0]      a_wdata;
    logic                  b_valid;
    logic                  b_ready;
    logic [REG_ADDR_W-1:0] b_waddr;
    logic [REG_W-1:0]      b_wdata;
    logic                  re1;
    logic [REG_ADDR_W-1:0] raddr1;
    logic                  re2;
    logic [REG_ADDR_W-1:0] raddr2;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [REG_W-1:0]      rf_wdata;
    logic                  stall_o;

    modport slave (
        input  a_we, a_waddr, a_wdata,
        input  b_valid, b_waddr, b_wdata,
        input  re1, raddr1, re2, raddr2,
        output b_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_o
    );

    modport master (
        output a_we, a_waddr, a_wdata,
        output b_valid, b_waddr, b_wdata,
        output re1, raddr1, re2, raddr2,
        input  b_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_o
    );

endinterface

// File: rtl/regfile_wr_fifo.sv
// Circular buffer of pending B-side writes.
//   clk, rst  : clock, async active-high reset (flushes pointers and count)
//   push      : enqueue push_data (ignored when full)
//   pop       : drop the head entry (ignored when empty)
//   full/empty: occupancy flags
//   head      : oldest entry, valid while !empty
//   count     : number of stored entries (log2(DEPTH)+1 bits)
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
module regfile_wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wr_entry_t              push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wr_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wr_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single regfile write port between the WB stage (A) and a
// multi-cycle unit (B). A normally wins; B results queue in a FIFO and drain
// when A is idle, or are forced through after the head has starved too long.
// A pending-register scoreboard stalls decode reads of not-yet-written B results.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_wr_arbiter_if.slave (A, B, decode reads, rf write port, stall_o)
// rf_*, b_ready and stall_o are combinational so the regfile write->read
// bypass keeps working; all of them are forced low while rst is high.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT - 1);

    arb_state_e        state_q, state_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [REG_NUM-1:0] pending_q, pending_d;

    logic              b_ready;
    logic              push;
    logic              pop;
    logic              force_stall;
    logic              hazard;
    logic              last_entry;
    logic              fifo_full;
    logic              fifo_empty;
    wr_entry_t         fifo_head;
    wr_entry_t         push_entry;
    logic [CNT_W-1:0]  fifo_count;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [REG_W-1:0]      rf_wdata;

    // B is refused while full or while its destination already has a result in flight.
    assign b_ready    = !rst && !fifo_full && !pending_q[bus.b_waddr];
    // Accepted writes to the zero register are silently dropped.
    assign push       = bus.b_valid && b_ready && !is_nop_addr(bus.b_waddr);
    assign push_entry = '{addr: bus.b_waddr, data: bus.b_wdata};
    assign last_entry = (fifo_count == CNT_W'(1));

    regfile_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // State, starvation counter and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            starve_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
        end
    end

    // Arbitration FSM: decides who owns the write port this cycle.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        pop         = 1'b0;
        force_stall = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (push) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (bus.a_we) begin
                    // The head loses again; once the count reaches LIMIT-1 the next cycle is forced.
                    starve_d = (starve_q == STV_MAX) ? STV_MAX : starve_q + STV_W'(1);
                    if (starve_d == STV_MAX) begin
                        state_d = ARB_FORCE;
                    end
                end else begin
                    pop      = 1'b1;
                    starve_d = '0;
                    if (last_entry && !push) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_FORCE: begin
                // Pipeline is frozen; A is dropped and re-presented next cycle.
                pop         = 1'b1;
                force_stall = 1'b1;
                starve_d    = '0;
                state_d     = (last_entry && !push) ? ARB_IDLE : ARB_DRAIN;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Scoreboard: set on enqueue, clear when the entry reaches the regfile.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[fifo_head.addr] = 1'b0;
        end
        if (push) begin
            pending_d[bus.b_waddr] = 1'b1;
        end
    end

    // Write-port mux; the FIFO head takes priority only on cycles the FSM pops.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = NOP_REG_ADDR;
        rf_wdata = ZERO_WORD;
        if (!rst) begin
            if (pop) begin
                rf_we    = 1'b1;
                rf_waddr = fifo_head.addr;
                rf_wdata = fifo_head.data;
            end else if (bus.a_we && !is_nop_addr(bus.a_waddr)) begin
                rf_we    = 1'b1;
                rf_waddr = bus.a_waddr;
                rf_wdata = bus.a_wdata;
            end
        end
    end

    // Read-after-write hazard on an in-flight B result.
    assign hazard = (bus.re1 && !is_nop_addr(bus.raddr1) && pending_q[bus.raddr1]) ||
                    (bus.re2 && !is_nop_addr(bus.raddr2) && pending_q[bus.raddr2]);

    assign bus.b_ready  = b_ready;
    assign bus.rf_we    = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.stall_o  = !rst && (hazard || force_stall);

    // A writing a register with a B result still in flight means the pipeline
    // ordering is broken upstream; nothing here can repair it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.a_we && !is_nop_addr(bus.a_waddr) && pending_q[bus.a_waddr]))
                else $error("regfile_wr_arbiter: WAW, A writes pending r%0d", bus.a_waddr);
            assert ((state_q == ARB_IDLE) == fifo_empty)
                else $error("regfile_wr_arbiter: IDLE state disagrees with FIFO occupancy");
        end
    end

endmodule
